// File: rtl/fact_pkg.sv
// Shared defaults and mux-select encodings for the factorial datapath.
package fact_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int N_W_DEF    = 4;
   localparam int MAX_N_DEF  = 12;

   localparam logic SEL_ONE  = 1'b0;
   localparam logic SEL_MUL  = 1'b1;
   localparam logic OUT_ZERO = 1'b0;
   localparam logic OUT_PROD = 1'b1;

endpackage

// File: rtl/factorial_dp_if.sv
// Controller <-> datapath bundle for factorial_dp; the controller is the master.
// The ovf status line exists only when FACTORIAL_DP_OVF_EN is defined.
interface factorial_dp_if import fact_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF
);
   logic [N_W-1:0]    n;
   logic              prod_mux_sel;
   logic              prod_reg_ld;
   logic              cnt_ld;
   logic              cnt_en;
   logic              out_mux_sel;
   logic              a_gt_b;
   logic              err;
   logic [DATA_W-1:0] result;
`ifdef FACTORIAL_DP_OVF_EN
   logic              ovf;
`endif

   modport master (
      output n, prod_mux_sel, prod_reg_ld, cnt_ld, cnt_en, out_mux_sel,
`ifdef FACTORIAL_DP_OVF_EN
      input  ovf,
`endif
      input  a_gt_b, err, result
   );

   modport slave (
      input  n, prod_mux_sel, prod_reg_ld, cnt_ld, cnt_en, out_mux_sel,
`ifdef FACTORIAL_DP_OVF_EN
      output ovf,
`endif
      output a_gt_b, err, result
   );
endinterface

// File: rtl/fact_down_cnt.sv
// Loadable down counter that saturates at zero; load beats enable.
module fact_down_cnt #(
   parameter int N_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           ld,
   input  logic           en,
   input  logic [N_W-1:0] d,
   output logic [N_W-1:0] q
);
   logic [N_W-1:0] q_reg;
   logic [N_W-1:0] q_next;

   always_comb begin
      q_next = q_reg;
      if (ld)
         q_next = d;
      else if (en && (q_reg != '0))
         q_next = q_reg - N_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         q_reg <= '0;
      else
         q_reg <= q_next;
   end

   assign q = q_reg;
endmodule

// File: rtl/factorial_dp.sv
// Factorial datapath: product register, down counter, single-cycle multiplier.
// Optional sticky overflow flag enabled by defining FACTORIAL_DP_OVF_EN.
module factorial_dp import fact_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int N_W    = N_W_DEF,
   parameter int MAX_N  = MAX_N_DEF
) (
   input logic           clk,
   input logic           rst,
   factorial_dp_if.slave bus
);
   logic [N_W-1:0]    cnt;
   logic [N_W-1:0]    mcand;
   logic [DATA_W-1:0] mul_out;
   logic [DATA_W-1:0] product_reg;
   logic [DATA_W-1:0] product_next;

   fact_down_cnt #(.N_W(N_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .ld  (bus.cnt_ld),
      .en  (bus.cnt_en),
      .d   (bus.n),
      .q   (cnt)
   );

   // A zero count multiplies by one so that 0! and 1! both settle at 1.
   assign mcand = (cnt == '0) ? N_W'(1) : cnt;

`ifdef FACTORIAL_DP_OVF_EN
   logic [DATA_W+N_W-1:0] mul_full;
   logic                  ovf_reg;

   assign mul_full = (DATA_W+N_W)'(product_reg) * (DATA_W+N_W)'(mcand);
   assign mul_out  = mul_full[DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (rst)
         ovf_reg <= 1'b0;
      else if (bus.prod_reg_ld) begin
         if (bus.prod_mux_sel == SEL_ONE)
            ovf_reg <= 1'b0;
         else if (|mul_full[DATA_W+N_W-1:DATA_W])
            ovf_reg <= 1'b1;
      end
   end

   assign bus.ovf = ovf_reg;
`else
   assign mul_out = product_reg * DATA_W'(mcand);
`endif

   always_comb begin
      product_next = product_reg;
      if (bus.prod_reg_ld)
         product_next = (bus.prod_mux_sel == SEL_ONE) ? DATA_W'(1) : mul_out;
   end

   always_ff @(posedge clk) begin
      if (rst)
         product_reg <= '0;
      else
         product_reg <= product_next;
   end

   assign bus.a_gt_b = (cnt > N_W'(1));
   assign bus.err    = (int'(bus.n) > MAX_N);
   assign bus.result = (bus.out_mux_sel == OUT_PROD) ? product_reg : '0;
endmodule

// File: tb/tb_factorial_dp.sv
// Scoreboard bench for factorial_dp: driver queues expectations, negedge monitor checks them.
module tb_factorial_dp;
   import fact_pkg::*;

`ifdef FACTORIAL_DP_OVF_EN
   localparam int MAX_N_TB = 15;
`else
   localparam int MAX_N_TB = 12;
`endif

   typedef struct {
      string       name;
      logic [31:0] result;
      logic        agt;
      logic        err;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [31:0] prod_m;
   int          cnt_m;
   logic        ovf_m;

   factorial_dp_if #(.DATA_W(32), .N_W(4)) bus ();

   factorial_dp #(.DATA_W(32), .N_W(4), .MAX_N(MAX_N_TB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cmp(e.name, "result", bus.result, e.result);
         cmp(e.name, "a_gt_b", 32'(bus.a_gt_b), 32'(e.agt));
         cmp(e.name, "err", 32'(bus.err), 32'(e.err));
`ifdef FACTORIAL_DP_OVF_EN
         cmp(e.name, "ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
         $display("check %-12s n=%0d result=0x%08h a_gt_b=%0b err=%0b", e.name, bus.n, bus.result, bus.a_gt_b, bus.err);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Queue an expectation for the current state, then let the monitor see it before inputs move.
   task automatic push(input string name, input logic [31:0] res, input logic agt);
      exp_t e;
      e.name   = name;
      e.result = res;
      e.agt    = agt;
      e.err    = (int'(bus.n) > MAX_N_TB);
      e.ovf    = ovf_m;
      sb.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic set_ctrl(input logic pld, input logic psel, input logic cld, input logic cen);
      bus.prod_reg_ld  = pld;
      bus.prod_mux_sel = psel;
      bus.cnt_ld       = cld;
      bus.cnt_en       = cen;
   endtask

   task automatic model_load(input int nv);
      prod_m = 32'd1;
      cnt_m  = nv;
      ovf_m  = 1'b0;
   endtask

   task automatic model_mul();
      logic [63:0] full;
      full = 64'(prod_m) * 64'((cnt_m == 0) ? 1 : cnt_m);
      if (full[63:32] != 32'd0)
         ovf_m = 1'b1;
      prod_m = full[31:0];
      cnt_m  = (cnt_m == 0) ? 0 : cnt_m - 1;
   endtask

   task automatic run_fact(input int nv, input logic [31:0] exp_res, input string tag);
      int mults;
      bus.n = 4'(nv);
      set_ctrl(1'b1, SEL_ONE, 1'b1, 1'b0);
      tick();
      model_load(nv);
      push({tag, "_load"}, prod_m, cnt_m > 1);
      mults = (nv < 2) ? 1 : nv - 1;
      for (int k = 0; k < mults; k++) begin
         set_ctrl(1'b1, SEL_MUL, 1'b0, 1'b1);
         tick();
         model_mul();
         push($sformatf("%s_mul%0d", tag, k + 1), prod_m, cnt_m > 1);
      end
      set_ctrl(1'b0, SEL_ONE, 1'b0, 1'b0);
      tick();
      push({tag, "_final"}, exp_res, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.n = 4'd0;
      bus.out_mux_sel = OUT_ZERO;
      set_ctrl(1'b0, SEL_ONE, 1'b0, 1'b0);
      prod_m = 32'd0;
      cnt_m  = 0;
      ovf_m  = 1'b0;
      repeat (2) tick();
      push("rst_zero", 32'd0, 1'b0);
      bus.out_mux_sel = OUT_PROD;
      push("rst_prod", 32'd0, 1'b0);
      rst = 1'b0;

      run_fact(5, 32'd120, "n5");
      bus.out_mux_sel = OUT_ZERO;
      push("n5_outzero", 32'd0, 1'b0);
      bus.out_mux_sel = OUT_PROD;

      run_fact(0, 32'd1, "n0");
      run_fact(1, 32'd1, "n1");
      run_fact(12, 32'd479001600, "n12");

      // Out-of-range operand with no loads: flags err, state untouched.
      bus.n = 4'd13;
      tick();
      push("n13_idle", 32'd479001600, 1'b0);

      // Abandon an n=6 run after its second multiply.
      bus.n = 4'd6;
      set_ctrl(1'b1, SEL_ONE, 1'b1, 1'b0);
      tick();
      model_load(6);
      push("n6_load", prod_m, 1'b1);
      for (int k = 0; k < 2; k++) begin
         set_ctrl(1'b1, SEL_MUL, 1'b0, 1'b1);
         tick();
         model_mul();
         push($sformatf("n6_mul%0d", k + 1), prod_m, cnt_m > 1);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prod_m = 32'd0;
      cnt_m  = 0;
      ovf_m  = 1'b0;
      set_ctrl(1'b0, SEL_ONE, 1'b0, 1'b0);
      push("n6_rst", 32'd0, 1'b0);

      run_fact(4, 32'd24, "n4");
      run_fact(13, 32'h7328CC00, "n13");
      run_fact(2, 32'd2, "n2");

      repeat (2) tick();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0 pending entries", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/factorial_dp.md
FACTORIAL_DP -- requirements
Module: factorial_dp

Interface
REQ-001 Parameter DATA_W, default 32, sets the product register and result width.
REQ-002 Parameter N_W, default 4, sets the operand and down-counter width.
REQ-003 Parameter MAX_N, default 12, is the largest operand accepted without err.
REQ-004 clk  input  1  single clock; all registers update on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 n  input  N_W  factorial operand, held stable by the requester while go is pending.
REQ-007 prod_mux_sel  input  1  product-register source select: 0 = constant 1, 1 = multiplier output.
REQ-008 prod_reg_ld  input  1  product-register load enable.
REQ-009 cnt_ld  input  1  loads n into the down counter.
REQ-010 cnt_en  input  1  down-counter enable.
REQ-011 out_mux_sel  input  1  result bus select: 0 = zero, 1 = product register.
REQ-012 a_gt_b  output  1  high when counter > 1.
REQ-013 err  output  1  high when n > MAX_N.
REQ-014 result  output  DATA_W  factorial result bus.

Function
REQ-015 Down counter priority: cnt_ld loads n regardless of cnt_en; otherwise cnt_en decrements by 1; otherwise it holds.
REQ-016 A decrement at count 0 saturates at 0; the counter never wraps to all-ones.
REQ-017 Multiplicand = counter, except when counter == 0, where it is 1, so that 0! = 1! = 1.
REQ-018 When prod_reg_ld is high: product <= 1 if prod_mux_sel = 0; else product <= product * multiplicand, truncated to the low DATA_W bits. With prod_reg_ld low, product holds.
REQ-019 On a cycle where prod_reg_ld, prod_mux_sel and cnt_en are all high, the multiply uses the pre-decrement count; both registers update on the same edge.
REQ-020 a_gt_b is combinational from the counter register only, with no dependence on n: it is valid one edge after a load or decrement.
REQ-021 err is combinational from n and is independent of all state.
REQ-022 result = out_mux_sel ? product : 0, combinational, with no added latency.
REQ-023 Latency from the load edge to the final product is n-1 multiply edges for n >= 2, and exactly 1 multiply edge for n in {0,1}.
REQ-024 Control inputs that arrive mid-sequence with cnt_ld high restart the count from the current n; the product is affected only via prod_reg_ld.

Reset
REQ-025 When rst is sampled high, counter <= 0 and product <= 0, so that a_gt_b = 0 and result = 0 while out_mux_sel = 0.
REQ-026 rst has priority over every control input on the same edge; a sequence in progress is abandoned and no partial product is retained.

Configuration
REQ-027 With macro FACTORIAL_DP_OVF_EN defined, the module adds output port ovf (1 bit), a sticky register.
REQ-028 ovf sets on any multiply load whose full-width product exceeds DATA_W bits, and clears on rst or on any load with prod_mux_sel = 0.
REQ-029 Without FACTORIAL_DP_OVF_EN, the ovf port and its logic are absent, and the remaining behaviour is identical.

Structure
REQ-030 A shared package fact_pkg holds the DATA_W/N_W/MAX_N defaults and the mux-select encodings (SEL_ONE = 0, SEL_MUL = 1, OUT_ZERO = 0, OUT_PROD = 1).
REQ-031 The down counter is a sub-module fact_down_cnt (parameter N_W; ports clk, rst, ld, en, d, q) implementing REQ-015 and REQ-016.
REQ-032 The multiplier is a single-cycle combinational multiply with no sub-module.

Verification
REQ-033 Drive n=5 with the standard controller sequence -> a_gt_b is high for 4 WAIT cycles; final result = 120 with out_mux_sel = 1.
REQ-034 Drive n=0, then n=1 -> each gives result = 1 after one multiply; a_gt_b stays 0 and the counter holds at 0.
REQ-035 Drive n=12 -> result = 479001600 (0x1C8CFC00); err = 0.
REQ-036 Drive n=13 -> err = 1 combinationally; with no loads issued, product and counter are unchanged.
REQ-037 Assert rst after the second multiply of n=6 -> on the next edge, counter = 0 and product = 0; a fresh n=4 run then gives 24.
REQ-038 With FACTORIAL_DP_OVF_EN, MAX_N = 15 and n=13 -> ovf rises on the multiply producing 13! (6227020800 > 2^32); the truncated result = 0x7328CC00; ovf clears on the next load with prod_mux_sel = 0.
